// File: rtl/stream_pkg.sv
// stream_pkg: shared defaults and width helpers for stream blocks.
package stream_pkg;

    localparam int DEF_DATA_WD = 4;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Pointer width carries one extra wrap bit to tell full from empty.
    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// stream_fifo_mem: unreset register array, one write port, combinational read port.
module stream_fifo_mem
    import stream_pkg::*;
#(
    parameter int DATA_WD = DEF_DATA_WD,
    parameter int DEPTH   = 8,
    parameter int AW      = clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [DATA_WD-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [DATA_WD-1:0] rdata
);

    logic [DATA_WD-1:0] mem_q [DEPTH];

    // Storage write; contents need no reset because reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready FIFO with registered in_ready, occupancy and almost-full.
// Optional STREAM_FIFO_BYPASS_EN: an empty FIFO forwards in_* to out_* combinationally.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int DATA_WD  = DEF_DATA_WD,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [DATA_WD-1:0]        in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [DATA_WD-1:0]        out_data,
    input  logic                      out_ready,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      almost_full
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d, count_q, count_d;
    logic               in_ready_q, afull_q;
    logic               empty, push, pop, wr_en, rd_en, bypass;
    logic [DATA_WD-1:0] rdata;

    assign empty = wr_q == rd_q;
    assign push  = in_valid && in_ready_q;

`ifdef STREAM_FIFO_BYPASS_EN
    assign out_valid = empty ? push : 1'b1;
    assign out_data  = empty ? (push ? in_data : '0) : rdata;
    assign bypass    = empty && push && out_ready;
`else
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : rdata;
    assign bypass    = 1'b0;
`endif

    assign pop   = out_valid && out_ready;
    assign wr_en = push && !bypass;
    assign rd_en = pop && !empty;

    // Next-state pointers and occupancy; a bypassed beat touches neither.
    always_comb begin
        wr_d    = wr_q + PW'(wr_en);
        rd_d    = rd_q + PW'(rd_en);
        count_d = count_q + PW'(wr_en) - PW'(rd_en);
    end

    // Pointer, count and flag registers; flags follow next_count so they move with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            afull_q    <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            in_ready_q <= count_d != PW'(DEPTH);
            afull_q    <= count_d >= PW'(AFULL_TH);
        end
    end

    stream_fifo_mem #(
        .DATA_WD (DATA_WD),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_q[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_q[AW-1:0]),
        .rdata (rdata)
    );

    assign in_ready    = in_ready_q;
    assign count       = count_q;
    assign almost_full = afull_q;

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed and scoreboard checks for stream_fifo (DEPTH=8, DATA_WD=4, AFULL_TH=6).
module tb_stream_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready, out_valid, almost_full;
    logic [3:0] out_data;
    logic [3:0] count;

    int n_cmp = 0;
    int n_err = 0;

    stream_fifo #(
        .DATA_WD  (4),
        .DEPTH    (8),
        .AFULL_TH (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] q[$];
        logic [3:0] seq;
        logic       exp_ir, exp_ov, exp_empty, p_push, p_pop, nv;
        logic [3:0] exp_od;
        int         pushed;

        // Reset held
        repeat (2) step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_out_data", out_data, 0);
        check("rst_afull", almost_full, 0);
        rst_n = 1'b1;
        #1 check("rel_ready_before_edge", in_ready, 0);
        step();
        check("rel_ready_after_edge", in_ready, 1);

        // Fill 0..7 with consumer stalled
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            step();
            check("fill_count", count, i + 1);
            check("fill_afull", almost_full, (i + 1 >= 6) ? 1 : 0);
            check("fill_head", out_data, 0);
        end
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        in_data = 4'd8;
        step();
        check("full_hold_count", count, 8);
        check("full_hold_ready", in_ready, 0);

        // Full boundary: first cycle pops only, then push+pop keeps count at 7
        out_ready = 1'b1;
        step();
        check("fb_count", count, 7);
        check("fb_in_ready", in_ready, 1);
        check("fb_head", out_data, 1);
        for (int k = 0; k < 6; k++) begin
            in_data = 4'(8 + k);
            step();
            check("pp_count", count, 7);
            check("pp_head", out_data, k + 2);
        end
        in_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            #1 check("drain_order", out_data, 7 + j);
            step();
        end
        check("drain_count", count, 0);
        check("drain_out_valid", out_valid, 0);
        check("drain_out_data", out_data, 0);

        // Random stress with scoreboard, wrapping 4-bit data
        seq       = '0;
        pushed    = 0;
        exp_ir    = 1'b1;
        in_valid  = 1'b0;
        in_data   = seq;
        out_ready = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 3000 && pushed < 200; cyc++) begin
            #1;
            exp_empty = q.size() == 0;
`ifdef STREAM_FIFO_BYPASS_EN
            exp_ov = exp_empty ? (in_valid && exp_ir) : 1'b1;
            exp_od = exp_empty ? (exp_ov ? in_data : 4'd0) : q[0];
`else
            exp_ov = !exp_empty;
            exp_od = exp_empty ? 4'd0 : q[0];
`endif
            check("st_in_ready", in_ready, exp_ir);
            check("st_out_valid", out_valid, exp_ov);
            check("st_out_data", out_data, exp_od);
            check("st_count", count, q.size());
            p_push = in_valid && exp_ir;
            p_pop  = exp_ov && out_ready;
            if (!(exp_empty && p_push && p_pop)) begin
                if (p_pop) void'(q.pop_front());
                if (p_push) q.push_back(in_data);
            end
            exp_ir = q.size() != 8;
            nv = in_valid;
            if (p_push) begin
                seq++;
                pushed++;
                nv = 1'($urandom_range(0, 1));
            end else if (!in_valid) begin
                nv = 1'($urandom_range(0, 1));
            end
            step();
            in_valid  = nv;
            in_data   = seq;
            out_ready = 1'($urandom_range(0, 1));
        end
        check("st_pushed", pushed, 200);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 20 && q.size() > 0; j++) begin
            #1 check("st_drain", out_data, q[0]);
            void'(q.pop_front());
            step();
        end
        check("st_end_count", count, 0);

        // Empty FIFO, beat offered with consumer ready
        in_valid  = 1'b1;
        in_data   = 4'd5;
        out_ready = 1'b1;
        #1;
`ifdef STREAM_FIFO_BYPASS_EN
        check("byp_out_valid", out_valid, 1);
        check("byp_out_data", out_data, 5);
        step();
        in_valid = 1'b0;
        #1 check("byp_count", count, 0);
        check("byp_after_valid", out_valid, 0);
`else
        check("nobyp_same_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        #1 check("nobyp_out_valid", out_valid, 1);
        check("nobyp_out_data", out_data, 5);
        check("nobyp_count", count, 1);
        step();
        check("nobyp_count_after", count, 0);
`endif

        // Reset in the middle of traffic
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(10 + i);
            step();
        end
        in_valid = 1'b0;
        check("mid_count", count, 5);
        check("mid_head", out_data, 10);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_afull", almost_full, 0);
        check("mid_rst_data", out_data, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_ready", in_ready, 1);
        check("post_rst_count", count, 0);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_data", out_data, 0);
        in_valid = 1'b1;
        in_data  = 4'd3;
        step();
        in_valid = 1'b0;
        #1 check("post_rst_head", out_data, 3);
        check("post_rst_count1", count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Synchronous valid/ready stream FIFO placed directly downstream of `stream_mux`. It absorbs `c_valid`/`c_data` bursts when the consumer stalls, preserves strict arrival order, and presents a registered-flag ready so no combinational path runs from `out_ready` back to `in_ready`. Occupancy and an almost-full flag are exported for flow-control monitoring.

## Interface
- `DATA_WD`, 4, payload width in bits.
- `DEPTH`, 8, number of entries; power of two, ≥ 2.
- `AFULL_TH`, DEPTH-2, `almost_full` asserts when `count >= AFULL_TH`.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream data valid (from `stream_mux.c_valid`).
- `in_data`  in  DATA_WD  upstream payload.
- `in_ready`  out  1  FIFO can accept; registered.
- `out_valid`  out  1  head entry available.
- `out_data`  out  DATA_WD  head entry payload.
- `out_ready`  in  1  downstream accepts.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `almost_full`  out  1  `count >= AFULL_TH`; registered.

## Operation
- Push fires on `in_valid && in_ready`; pop fires on `out_valid && out_ready`.
- Storage: DEPTH-entry register array, not reset. Pointers `wr_ptr`, `rd_ptr` are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- Empty: pointers equal. Full: MSBs differ, lower bits equal. Pointers wrap naturally modulo 2·DEPTH.
- `count` = `wr_ptr - rd_ptr`, truncated to pointer width. It is held in a register and updated as +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- `in_ready` register: reset to 0. Each cycle it loads `!(next_count == DEPTH)`, so it is 1 from the first edge after reset release.
- Full with `out_ready=1`: push is refused that cycle (`in_ready=0`); the pop proceeds; `in_ready` returns to 1 next cycle.
- `out_valid = !empty`. `out_data = mem[rd_ptr]` when non-empty, otherwise 0.
- Data width arithmetic: payload is stored unmodified; no width conversion.
- Upstream obligation: `in_valid`/`in_data` held stable until accepted. The FIFO guarantees the same for `out_valid`/`out_data` until popped.

## Timing
- Reset (async assert, synchronous effect on release): `in_ready=0`, `out_valid=0`, `out_data=0`, `count=0`, `almost_full=0`, pointers 0.
- Reset asserted mid-operation: all contents discarded immediately; outputs take reset values in the same cycle.
- Default latency: a push at edge N is visible as `out_valid=1` after edge N (i.e. in cycle N+1).
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- `almost_full` updates on the same edge as `count`.

## Configuration
- `STREAM_FIFO_BYPASS_EN` defined: when the FIFO is empty, `out_valid = in_valid` and `out_data = in_data` combinationally.
  - If `out_ready=1`, the beat passes with zero latency and is not written; `count` stays 0.
  - If `out_ready=0`, the beat is written normally and remains presented next cycle.
- `STREAM_FIFO_BYPASS_EN` undefined: no `in_*`→`out_*` combinational path; latency is 1 cycle as above.

## Structure
- `stream_pkg` holds the default `DATA_WD`, the `clog2` helper function, and the pointer-width calculation shared with `stream_mux` and future stream blocks.
- One sub-module, `stream_fifo_mem`: register array with write port (`we`, `waddr`, `wdata`) and combinational read port. Pointer, count and flag logic stay in `stream_fifo`.

## Test plan
All scenarios use DEPTH=8, DATA_WD=4, AFULL_TH=6.
- Reset: hold `rst_n=0` → `in_ready=0`, `out_valid=0`, `count=0`, `out_data=0`; first edge after release → `in_ready=1`.
- Fill: push 0..7 with `out_ready=0` → `almost_full=1` once `count=6`; after 8th push `count=8`, `in_ready=0`; value 8 is held and not accepted.
- Drain and full-boundary pop: from full, `out_ready=1`, `in_valid=1` → cycle 1 pops 0 only (`count=7`), `in_ready=1` next cycle. Subsequent simultaneous push/pop keeps `count=7`; outputs appear in order 0,1,2….
- Wrap and random stress: 200 beats, incrementing 4-bit data (15→0 wrap), random `in_valid`/`out_ready` → scoreboard order matches; `count` never exceeds 8 or underflows.
- Bypass: empty FIFO, `in_valid=1`, `in_data=5`, `out_ready=1`:
  - With macro → same-cycle `out_valid=1`, `out_data=5`, `count` stays 0.
  - Without macro → `out_valid=1`, `out_data=5` one cycle later.
- Reset mid-operation: `count=5`, assert `rst_n=0` → `out_valid=0`, `count=0` immediately; after release, the FIFO is empty and reads back no stale data.
